// File: rtl/br_mask_ctrl_mw_if.sv
`default_nettype none
// ============================================================================
// Module      : br_mask_ctrl_mw_if
// Description : Dispatch/ROB/RS side bundle of the multi-dispatch branch
//               mask controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface br_mask_ctrl_mw_if #(
    parameter int BR_MASK_W = 5,
    parameter int DISP_W    = 2
);
    localparam int CNT_W = $clog2(BR_MASK_W + 1);

    logic [DISP_W-1:0]           is_br_i;
    logic [1:0]                  br_state_i;
    logic [BR_MASK_W-1:0]        br_tag_i;
    logic [DISP_W-1:0]           br_ack_o;
    logic [DISP_W*BR_MASK_W-1:0] br_tag_o;
    logic [DISP_W*BR_MASK_W-1:0] br_mask_o;
    logic [BR_MASK_W-1:0]        br_bit_o;
    logic [BR_MASK_W-1:0]        br_squash_o;
    logic [CNT_W-1:0]            free_cnt_o;
    logic                        full_o;

    modport master (
        output is_br_i, br_state_i, br_tag_i,
        input  br_ack_o, br_tag_o, br_mask_o, br_bit_o, br_squash_o,
               free_cnt_o, full_o
    );

    modport slave (
        input  is_br_i, br_state_i, br_tag_i,
        output br_ack_o, br_tag_o, br_mask_o, br_bit_o, br_squash_o,
               free_cnt_o, full_o
    );
endinterface
`default_nettype wire

// File: rtl/br_mask_ctrl_mw.sv
`default_nettype none
// ============================================================================
// Module      : br_mask_ctrl_mw
// Description : Multi-dispatch one-hot branch tag allocator with per-tag
//               older-branch snapshots for single-cycle mispredict squash.
// Revision    : 1.0 - initial release
// ============================================================================
module br_mask_ctrl_mw #(
    parameter int BR_MASK_W = 5,
    parameter int DISP_W    = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    br_mask_ctrl_mw_if.slave   bus
);
    localparam int         CNT_W           = $clog2(BR_MASK_W + 1);
    localparam logic [1:0] c_BR_PR_CORRECT = 2'b01;
    localparam logic [1:0] c_BR_PR_WRONG   = 2'b10;

    logic [BR_MASK_W-1:0]                r_valid;
    logic [BR_MASK_W-1:0][BR_MASK_W-1:0] r_snap;

    logic                                w_onehot;
    logic                                w_res_valid;
    logic                                w_correct;
    logic                                w_wrong;
    logic [BR_MASK_W-1:0]                w_bit;
    logic [BR_MASK_W-1:0]                w_squash;
    logic [BR_MASK_W-1:0]                w_clear;
    logic [BR_MASK_W-1:0]                w_live;
    logic [BR_MASK_W-1:0]                w_taken;
    logic [BR_MASK_W-1:0]                w_cand;
    logic [BR_MASK_W-1:0]                w_pick;
    logic                                w_blocked;
    logic [DISP_W-1:0]                   w_ack;
    logic [DISP_W-1:0][BR_MASK_W-1:0]    w_slot_tag;
    logic [DISP_W-1:0][BR_MASK_W-1:0]    w_slot_snap;
    logic [DISP_W-1:0][BR_MASK_W-1:0]    w_slot_mask;
    logic [CNT_W-1:0]                    w_free_cnt;

    // Resolve qualification and squash set
    always_comb begin
        w_onehot    = (bus.br_tag_i != '0) &&
                      ((bus.br_tag_i & (bus.br_tag_i - BR_MASK_W'(1))) == '0);
        w_res_valid = w_onehot && ((bus.br_tag_i & r_valid) != '0) &&
                      ((bus.br_state_i == c_BR_PR_CORRECT) ||
                       (bus.br_state_i == c_BR_PR_WRONG));
        w_correct   = w_res_valid && (bus.br_state_i == c_BR_PR_CORRECT);
        w_wrong     = w_res_valid && (bus.br_state_i == c_BR_PR_WRONG);
        w_bit       = w_res_valid ? bus.br_tag_i : '0;
        w_squash    = w_wrong ? bus.br_tag_i : '0;
        for (int u = 0; u < BR_MASK_W; u++) begin
            // A younger branch recorded the mispredicted tag as older at allocation.
            if (w_wrong && r_valid[u] && ((r_snap[u] & bus.br_tag_i) != '0))
                w_squash[u] = 1'b1;
        end
        w_clear = (w_correct ? bus.br_tag_i : '0) | w_squash;
        w_live  = r_valid & ~(w_correct ? bus.br_tag_i : '0);
    end

    // In-order slot allocation from the registered free set
    always_comb begin
        w_taken     = '0;
        w_cand      = '0;
        w_pick      = '0;
        w_blocked   = w_wrong;
        w_ack       = '0;
        w_slot_tag  = '0;
        w_slot_snap = '0;
        w_slot_mask = '0;
        for (int k = 0; k < DISP_W; k++) begin
            w_cand = ~r_valid & ~w_taken;
            w_pick = w_cand & (~w_cand + BR_MASK_W'(1));
            if (bus.is_br_i[k] && !w_blocked) begin
                if (w_cand != '0) begin
                    w_ack[k]       = 1'b1;
                    w_slot_tag[k]  = w_pick;
                    w_slot_snap[k] = w_live | w_taken;
                    w_taken        = w_taken | w_pick;
                end else begin
                    w_blocked = 1'b1;
                end
            end
            w_slot_mask[k] = w_live | w_taken;
        end
    end

    always_comb begin
        w_free_cnt = '0;
        for (int i = 0; i < BR_MASK_W; i++) begin
            if (!r_valid[i])
                w_free_cnt = w_free_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_snap  <= '0;
        end else begin
            r_valid <= (r_valid & ~w_clear) | w_taken;
            for (int t = 0; t < BR_MASK_W; t++) begin
                r_snap[t] <= r_snap[t] & ~w_clear;
                for (int k = 0; k < DISP_W; k++) begin
                    if (w_slot_tag[k][t])
                        r_snap[t] <= w_slot_snap[k];
                end
            end
        end
    end

    assign bus.br_ack_o    = w_ack;
    assign bus.br_tag_o    = w_slot_tag;
    assign bus.br_mask_o   = w_slot_mask;
    assign bus.br_bit_o    = w_bit;
    assign bus.br_squash_o = w_squash;
    assign bus.free_cnt_o  = w_free_cnt;
    assign bus.full_o      = (w_free_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_br_mask_ctrl_mw.sv
`default_nettype none
// ============================================================================
// Module      : tb_br_mask_ctrl_mw
// Description : Directed self-checking bench for br_mask_ctrl_mw (5 tags, 2 slots).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_br_mask_ctrl_mw;
    localparam int         BR_MASK_W = 5;
    localparam int         DISP_W    = 2;
    localparam logic [1:0] c_NONE    = 2'b00;
    localparam logic [1:0] c_CORRECT = 2'b01;
    localparam logic [1:0] c_WRONG   = 2'b10;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    br_mask_ctrl_mw_if #(.BR_MASK_W(BR_MASK_W), .DISP_W(DISP_W)) bus ();

    br_mask_ctrl_mw #(.BR_MASK_W(BR_MASK_W), .DISP_W(DISP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge and settle before sampling.
    task automatic step(input logic [1:0] is_br, input logic [1:0] st, input logic [4:0] tag);
        @(negedge clk);
        bus.is_br_i    = is_br;
        bus.br_state_i = st;
        bus.br_tag_i   = tag;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.is_br_i    = '0;
        bus.br_state_i = c_NONE;
        bus.br_tag_i   = '0;
        repeat (2) @(posedge clk);
        step(2'b00, c_NONE, 5'b00000);
        check("rst_free", 32'(bus.free_cnt_o), 32'd5);
        check("rst_full", 32'(bus.full_o), 32'd0);
        check("rst_ack",  32'(bus.br_ack_o), 32'd0);
        check("rst_mask", 32'(bus.br_mask_o), 32'd0);
        rst = 1'b0;

        // Fill all tags, two per cycle
        step(2'b11, c_NONE, 5'b00000);
        check("c1_ack",  32'(bus.br_ack_o), 32'b11);
        check("c1_tag",  32'(bus.br_tag_o), 32'b00010_00001);
        check("c1_mask", 32'(bus.br_mask_o), 32'b00011_00001);
        step(2'b11, c_NONE, 5'b00000);
        check("c2_tag",  32'(bus.br_tag_o), 32'b01000_00100);
        check("c2_mask", 32'(bus.br_mask_o), 32'b01111_00111);
        step(2'b11, c_NONE, 5'b00000);
        check("c3_ack",  32'(bus.br_ack_o), 32'b01);
        check("c3_tag",  32'(bus.br_tag_o), 32'b00000_10000);
        check("c3_mask", 32'(bus.br_mask_o), 32'b11111_11111);
        step(2'b00, c_NONE, 5'b00000);
        check("full",      32'(bus.full_o), 32'd1);
        check("full_free", 32'(bus.free_cnt_o), 32'd0);

        // Correct resolve of tag 2
        step(2'b00, c_CORRECT, 5'b00100);
        check("cor_bit",    32'(bus.br_bit_o), 32'b00100);
        check("cor_squash", 32'(bus.br_squash_o), 32'd0);
        check("cor_free_same", 32'(bus.free_cnt_o), 32'd0);
        step(2'b00, c_NONE, 5'b00000);
        check("cor_free", 32'(bus.free_cnt_o), 32'd1);
        check("cor_full", 32'(bus.full_o), 32'd0);

        // Mispredict of tag 1 kills tags 3 and 4, whose snapshots no longer hold tag 2
        step(2'b00, c_WRONG, 5'b00010);
        check("wr_squash", 32'(bus.br_squash_o), 32'b11010);
        check("wr_bit",    32'(bus.br_bit_o), 32'b00010);
        step(2'b00, c_NONE, 5'b00000);
        check("wr_free", 32'(bus.free_cnt_o), 32'd4);
        check("wr_full", 32'(bus.full_o), 32'd0);
        step(2'b11, c_NONE, 5'b00000);
        check("realloc_tag",  32'(bus.br_tag_o), 32'b00100_00010);
        check("realloc_mask", 32'(bus.br_mask_o), 32'b00111_00011);

        // Mispredict blocks allocation in the same cycle
        step(2'b11, c_WRONG, 5'b00010);
        check("wr_alloc_ack",    32'(bus.br_ack_o), 32'd0);
        check("wr_alloc_tag",    32'(bus.br_tag_o), 32'd0);
        check("wr_alloc_squash", 32'(bus.br_squash_o), 32'b00110);
        step(2'b00, c_NONE, 5'b00000);
        check("wr_alloc_free", 32'(bus.free_cnt_o), 32'd4);

        // Tag freed this cycle is not reused in the same cycle
        step(2'b01, c_CORRECT, 5'b00001);
        check("cor_alloc_ack",  32'(bus.br_ack_o), 32'b01);
        check("cor_alloc_tag",  32'(bus.br_tag_o), 32'b00000_00010);
        check("cor_alloc_mask", 32'(bus.br_mask_o), 32'b00010_00010);
        check("cor_alloc_bit",  32'(bus.br_bit_o), 32'b00001);
        step(2'b00, c_CORRECT, 5'b00001);
        check("tag0_gone_bit", 32'(bus.br_bit_o), 32'd0);
        check("valid_1_free",  32'(bus.free_cnt_o), 32'd4);
        step(2'b00, c_CORRECT, 5'b00010);
        check("tag1_live_bit", 32'(bus.br_bit_o), 32'b00010);
        step(2'b00, c_NONE, 5'b00000);
        check("all_free", 32'(bus.free_cnt_o), 32'd5);

        // Ignored resolves with valid=00001
        step(2'b01, c_NONE, 5'b00000);
        check("alloc_t0", 32'(bus.br_tag_o), 32'b00000_00001);
        step(2'b00, c_WRONG, 5'b00100);
        check("inv_tag_bit",    32'(bus.br_bit_o), 32'd0);
        check("inv_tag_squash", 32'(bus.br_squash_o), 32'd0);
        step(2'b00, 2'b11, 5'b00001);
        check("st11_bit", 32'(bus.br_bit_o), 32'd0);
        step(2'b00, c_WRONG, 5'b00011);
        check("noh_bit",    32'(bus.br_bit_o), 32'd0);
        check("noh_squash", 32'(bus.br_squash_o), 32'd0);
        step(2'b00, c_NONE, 5'b00000);
        check("ignored_free", 32'(bus.free_cnt_o), 32'd4);

        // Reset dominates a concurrent allocation request
        @(negedge clk);
        rst         = 1'b1;
        bus.is_br_i = 2'b11;
        @(negedge clk);
        rst         = 1'b0;
        bus.is_br_i = 2'b00;
        #1;
        check("rst2_free", 32'(bus.free_cnt_o), 32'd5);
        check("rst2_ack",  32'(bus.br_ack_o), 32'd0);
        check("rst2_tag",  32'(bus.br_tag_o), 32'd0);
        check("rst2_mask", 32'(bus.br_mask_o), 32'd0);
        check("rst2_full", 32'(bus.full_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/br_mask_ctrl_mw.md
Name: br_mask_ctrl_mw

Overview:
- Parametrised, multi-dispatch successor to the branch mask controller.
- Allocates one-hot branch tags to up to DISP_W branches per cycle and supplies a dependency mask per dispatch slot.
- Keeps a per-tag snapshot of older in-flight branches, so a mispredict kills the resolved tag and every younger tag in one cycle.
- Sits between Dispatch, ROB, RS and the map-table stacks.

Parameters:
- BR_MASK_W, 5, number of branch tags (bits in the mask); must be ≥2.
- DISP_W, 2, dispatch slots per cycle; must be ≥1 and ≤BR_MASK_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- is_br_i  in  DISP_W  [Dispatch] slot k holds a branch requesting a tag.
- br_state_i  in  2  [ROB] 00 none, `BR_PR_CORRECT, `BR_PR_WRONG; 11 is treated as none.
- br_tag_i  in  BR_MASK_W  [ROB] one-hot tag of the branch being resolved.
- br_ack_o  out  DISP_W  [Dispatch] slot k was granted a tag this cycle.
- br_tag_o  out  DISP_W*BR_MASK_W  [ROB][Stacks] one-hot tag granted to slot k; 0 if not granted.
- br_mask_o  out  DISP_W*BR_MASK_W  [ROB][RS] dependency mask carried by instructions in slot k.
- br_bit_o  out  BR_MASK_W  [RS] resolved tag, for clear or squash.
- br_squash_o  out  BR_MASK_W  [RS][ROB] all tags killed by a mispredict.
- free_cnt_o  out  $clog2(BR_MASK_W+1)  number of free tags (registered state).
- full_o  out  1  [ROB] no free tags.

Behaviour:
- State:
  - valid[BR_MASK_W]: in-flight tags.
  - snap[t][BR_MASK_W]: tags older than t, captured at t's allocation.
  - Reset: valid=0, all snap=0. All outputs are combinational from state and inputs, so at reset free_cnt_o=BR_MASK_W, full_o=0 and every other output is 0.
- Resolve validity: a resolve is valid when br_state_i is CORRECT or WRONG, br_tag_i is one-hot, and (br_tag_i & valid)≠0. Otherwise the resolve is ignored and br_bit_o=br_squash_o=0.
- Correct resolve (same cycle, combinational):
  - br_bit_o=br_tag_i.
  - At posedge: clear the tag from valid and from every snap.
- Wrong resolve:
  - br_bit_o=br_tag_i.
  - br_squash_o = br_tag_i | OR of every valid tag u whose snap[u] contains br_tag_i.
  - At posedge: valid &= ~br_squash_o; clear squashed bits from every snap; no allocation this cycle (br_ack_o=0).
- Allocation (only when no wrong resolve is valid this cycle):
  - Free set = ~valid from registered state. Tags freed this cycle are not reusable until the next cycle.
  - Slots are scanned 0..DISP_W-1 in order; each requesting slot takes the lowest-index free tag not already taken by an earlier slot this cycle.
  - If no tag remains, that slot and every later slot get ack=0 (in-order dispatch).
  - Non-requesting slots do not block later slots.
- Mask per slot: let live = valid & ~(tag cleared by a correct resolve this cycle). Then br_mask_o[k] = live | tags granted to slots 0..k.
- Snapshot capture: on grant of tag t to slot k, at posedge set valid[t]=1 and snap[t] = live | tags granted to slots <k.
- Counters: free_cnt_o=popcount(~valid); full_o=(free_cnt_o==0). Both reflect registered state, not this cycle's grants.
- Reset dominates all inputs; a reset mid-operation returns to the reset state in one cycle.

Test Plan (BR_MASK_W=5, DISP_W=2):
1. After reset, is_br_i=11 for 3 cycles ->
   - cycle 1: ack=11, tags 00001/00010, masks 00001/00011.
   - cycle 2: tags 00100/01000, masks 00111/01111.
   - cycle 3: ack=01, tag0=10000, mask0=mask1=11111.
   - then full_o=1, free_cnt_o=0.
2. From full, CORRECT with br_tag_i=00100 -> br_bit_o=00100, br_squash_o=0 same cycle; next cycle valid=11011, free_cnt_o=1, snaps of 01000 and 10000 lack bit 2.
3. Then WRONG with br_tag_i=00010 -> br_squash_o=11010, br_bit_o=00010; next cycle free_cnt_o=4, full_o=0; a following is_br_i=11 gets tags 00010/00100, masks 00011/00111.
4. WRONG resolve with is_br_i=11 in the same cycle -> ack=00, tag outputs 0, no allocation.
5. CORRECT on tag 00001 with is_br_i=01 in the same cycle, valid=00001 -> grant 00010 (not 00001), mask0=00010; next cycle valid=00010.
6. Resolve of an invalid tag (00100 when valid=00001), br_state_i=11, and non-one-hot br_tag_i -> all ignored, outputs 0; rst asserted with valid≠0 -> next cycle free_cnt_o=5, all outputs 0.
